// File: rtl/cim_row_ctrl.sv
// Row sequencer for a compute-in-memory array: turns WRITE / READ / SEARCH / MAC
// commands into row-decoder, bitline, precharge and sense-amp strobes, and
// returns a 5-bit result over a valid/ready response channel.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a command; decoder outputs parked (WL low, WLB high)
// PRE   | bitline/matchline precharge strobe
// ACT   | row/key driven onto the array (WRITE completes here)
// SENSE | sense-amp strobe; sa_out captured or accumulated
// DONE  | response held until rsp_ready
module cim_row_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_addr,
    input  logic [3:0] cmd_data,
    output logic       MAC_en,
    output logic       read_bar,
    output logic       addr0,
    output logic       addr1,
    output logic       data0,
    output logic       data1,
    output logic       data2,
    output logic       data3,
    output logic [3:0] bl_data,
    output logic       precharge,
    output logic       sense_en,
    input  logic [3:0] sa_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [4:0] rsp_data,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ACT,
        S_SENSE,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_READ   = 2'b01;
    localparam logic [1:0] OP_SEARCH = 2'b10;
    localparam logic [1:0] OP_MAC    = 2'b11;

    state_t     state, state_nxt;
    logic [1:0] op_q;
    logic [1:0] addr_q;
    logic [3:0] data_q;
    logic [1:0] row_q;
    logic [4:0] acc_q;
    logic       accept;
    logic       idle_c;
    logic [1:0] addr_c;
    logic [3:0] data_c;

    function automatic logic [4:0] popcnt4(input logic [3:0] v);
        return 5'(v[0]) + 5'(v[1]) + 5'(v[2]) + 5'(v[3]);
    endfunction

    assign accept = cmd_valid && (state == S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command capture at acceptance; commands offered while busy never reach these registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q   <= 2'b00;
            addr_q <= 2'b00;
            data_q <= 4'b0000;
        end else if (accept) begin
            op_q   <= cmd_op;
            addr_q <= cmd_addr;
            data_q <= cmd_data;
        end
    end

    // MAC row counter; it holds at row 3 since the last SENSE exits to DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q <= 2'b00;
        end else if (accept) begin
            row_q <= 2'b00;
        end else if (state == S_SENSE && op_q == OP_MAC && row_q != 2'b11) begin
            row_q <= row_q + 2'b01;
        end
    end

    // Result register: sa_out capture for READ/SEARCH, masked popcount accumulation for MAC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= 5'd0;
        end else if (accept) begin
            acc_q <= 5'd0;
        end else if (state == S_SENSE) begin
            if (op_q == OP_MAC) begin
                acc_q <= acc_q + popcnt4(sa_out & data_q);
            end else begin
                acc_q <= {1'b0, sa_out};
            end
        end
    end

    // Next-state and state-decoded array controls.
    always_comb begin
        state_nxt = state;
        idle_c    = 1'b0;
        MAC_en    = 1'b0;
        read_bar  = 1'b0;
        addr_c    = 2'b00;
        data_c    = 4'b0000;
        bl_data   = 4'b0000;
        precharge = 1'b0;
        sense_en  = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = 5'd0;
        unique case (state)
            S_IDLE: begin
                idle_c = 1'b1;
                if (cmd_valid) begin
                    state_nxt = (cmd_op == OP_WRITE) ? S_ACT : S_PRE;
                end
            end
            S_PRE: begin
                precharge = 1'b1;
                state_nxt = S_ACT;
            end
            S_ACT, S_SENSE: begin
                sense_en = (state == S_SENSE);
                unique case (op_q)
                    OP_WRITE: begin
                        MAC_en   = 1'b1;
                        read_bar = 1'b1;
                        addr_c   = addr_q;
                        bl_data  = data_q;
                    end
                    OP_READ: begin
                        MAC_en = 1'b1;
                        addr_c = addr_q;
                    end
                    OP_SEARCH: begin
                        data_c = data_q;
                    end
                    OP_MAC: begin
                        MAC_en = 1'b1;
                        addr_c = row_q;
                    end
                    default: ;
                endcase
                if (state == S_ACT) begin
                    state_nxt = (op_q == OP_WRITE) ? S_DONE : S_SENSE;
                end else begin
                    state_nxt = (op_q == OP_MAC && row_q != 2'b11) ? S_PRE : S_DONE;
                end
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                rsp_data  = acc_q;
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Decoder pin fan-out and status flags; cmd_ready is held low while reset is applied.
    assign addr0     = addr_c[0];
    assign addr1     = addr_c[1];
    assign data0     = data_c[0];
    assign data1     = data_c[1];
    assign data2     = data_c[2];
    assign data3     = data_c[3];
    assign busy      = (state != S_IDLE);
    assign cmd_ready = idle_c && rst_n;

endmodule

// File: tb/tb_cim_row_ctrl.sv
// Bench for cim_row_ctrl: a directed driver walks each command cycle by cycle
// and checks the array controls, while a scoreboard monitor checks response
// data and latency independently of the driver.
module tb_cim_row_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [1:0] cmd_addr = 2'b00;
    logic [3:0] cmd_data = 4'b0000;
    logic       MAC_en, read_bar, addr0, addr1, data0, data1, data2, data3;
    logic [3:0] bl_data;
    logic       precharge, sense_en;
    logic [3:0] sa_out;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [4:0] rsp_data;
    logic       busy;

    logic [3:0] sa_tbl [4];
    int         ncyc = 0;
    int         errors = 0;
    int         checks = 0;
    bit         prev_v = 1'b0;

    typedef struct {
        logic [4:0] data;
        int         due;
    } exp_t;
    exp_t sb[$];

    cim_row_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .MAC_en(MAC_en), .read_bar(read_bar), .addr0(addr0), .addr1(addr1),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .bl_data(bl_data), .precharge(precharge), .sense_en(sense_en),
        .sa_out(sa_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    // Array model: sense-amp result depends on the row being addressed.
    always_comb sa_out = sa_tbl[{addr1, addr0}];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // {MAC_en, read_bar, addr1, addr0, data3..0, bl_data, precharge, sense_en, busy, cmd_ready, rsp_valid}
    function automatic logic [16:0] get_ctl();
        return {MAC_en, read_bar, addr1, addr0, data3, data2, data1, data0,
                bl_data, precharge, sense_en, busy, cmd_ready, rsp_valid};
    endfunction

    function automatic logic [16:0] idle_vec(input logic cr);
        return {15'b0, cr, 1'b0};
    endfunction

    // Expected controls d cycles after acceptance of a command whose response is due at d=lat.
    function automatic logic [16:0] exp_ctl(input logic [1:0] op, input logic [1:0] addr,
                                            input logic [3:0] data, input int d, input int lat);
        logic       mac, rb, pre, sen;
        logic [1:0] a, row;
        logic [3:0] dl, bl;
        int         p;
        mac = 1'b0; rb = 1'b0; pre = 1'b0; sen = 1'b0;
        a = 2'b00; dl = 4'b0000; bl = 4'b0000;
        if (d >= lat) return 17'b101;
        if (op == 2'b00) begin
            mac = 1'b1; rb = 1'b1; a = addr; bl = data;
        end else begin
            p   = (d - 1) % 3;
            row = (op == 2'b11) ? 2'((d - 1) / 3) : addr;
            if (p == 0) begin
                pre = 1'b1;
            end else begin
                sen = (p == 2);
                if (op == 2'b01) begin
                    mac = 1'b1; a = addr;
                end else if (op == 2'b10) begin
                    dl = data;
                end else begin
                    mac = 1'b1; a = row;
                end
            end
        end
        return {mac, rb, a, dl, bl, pre, sen, 1'b1, 1'b0, 1'b0};
    endfunction

    // Issue one command, walk its sequence, then hold the response for `hold` cycles.
    // abort_at > 0 applies reset at that cycle instead of completing.
    task automatic run_cmd(input logic [1:0] op, input logic [1:0] addr, input logic [3:0] data,
                           input logic [4:0] exp_rsp, input int hold, input int abort_at);
        int  lat;
        bit  aborted;
        lat = (op == 2'b00) ? 2 : (op == 2'b11) ? 13 : 4;
        aborted = 1'b0;
        @(negedge clk);
        check("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
        sb.push_back('{exp_rsp, ncyc + lat});
        for (int d = 1; d <= lat + hold; d++) begin
            @(negedge clk);
            check($sformatf("ctl op%0d d%0d", op, d), 32'(get_ctl()), 32'(exp_ctl(op, addr, data, d, lat)));
            if (d == abort_at) begin
                rst_n = 1'b0;
                cmd_valid = 1'b0;
                sb.delete();
                aborted = 1'b1;
                break;
            end
            // Offer a conflicting command while busy; it must be ignored.
            cmd_valid = (d < lat);
            cmd_op = ~op; cmd_addr = ~addr; cmd_data = ~data;
            if (d == lat + hold) rsp_ready = 1'b1;
        end
        if (aborted) begin
            repeat (2) begin
                @(negedge clk);
                check("ctl_in_reset", 32'(get_ctl()), 32'(idle_vec(1'b0)));
                check("rsp_data_in_reset", 32'(rsp_data), 32'd0);
            end
            rst_n = 1'b1;
            @(negedge clk);
            check("ctl_after_abort", 32'(get_ctl()), 32'(idle_vec(1'b1)));
        end else begin
            @(negedge clk);
            rsp_ready = 1'b0;
            check("ctl_back_to_idle", 32'(get_ctl()), 32'(idle_vec(1'b1)));
        end
    endtask

    // Response monitor: latency on the rising valid, data on every valid cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 data=0x%0h expected no response", rsp_data);
                end else begin
                    if (!prev_v) check("rsp_latency", 32'(ncyc), 32'(sb[0].due));
                    check("rsp_data", 32'(rsp_data), 32'(sb[0].data));
                end
            end else if (sb.size() > 0 && ncyc > sb[0].due + 40) begin
                checks++;
                errors++;
                $display("FAIL rsp_timeout: got no response expected data 0x%0h", sb[0].data);
                void'(sb.pop_front());
            end
            prev_v = rsp_valid;
        end
    end

    // Retire the expected entry on the handshake edge.
    always @(posedge clk) begin
        if (rst_n && rsp_valid && rsp_ready && sb.size() > 0) void'(sb.pop_front());
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4; i++) sa_tbl[i] = 4'b0000;
        repeat (3) @(negedge clk);
        check("reset_ctl", 32'(get_ctl()), 32'(idle_vec(1'b0)));
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ctl", 32'(get_ctl()), 32'(idle_vec(1'b1)));

        run_cmd(2'b00, 2'd2, 4'b1011, 5'd0, 0, 0);

        for (int i = 0; i < 4; i++) sa_tbl[i] = 4'b0110;
        run_cmd(2'b01, 2'd1, 4'b0000, 5'b00110, 3, 0);

        for (int i = 0; i < 4; i++) sa_tbl[i] = 4'b0001;
        run_cmd(2'b10, 2'd0, 4'b1100, 5'b00001, 0, 0);

        for (int i = 0; i < 4; i++) sa_tbl[i] = 4'b1111;
        run_cmd(2'b11, 2'd0, 4'b1111, 5'd16, 1, 0);

        sa_tbl[0] = 4'b1111; sa_tbl[1] = 4'b0011; sa_tbl[2] = 4'b1010; sa_tbl[3] = 4'b0000;
        run_cmd(2'b11, 2'd3, 4'b1010, 5'd5, 0, 0);

        sa_tbl[3] = 4'b1001;
        run_cmd(2'b01, 2'd3, 4'b0000, 5'b01001, 1, 0);

        for (int i = 0; i < 4; i++) sa_tbl[i] = 4'b1111;
        run_cmd(2'b11, 2'd0, 4'b1111, 5'd16, 0, 8);

        sa_tbl[2] = 4'b0101;
        run_cmd(2'b01, 2'd2, 4'b0000, 5'b00101, 0, 0);

        run_cmd(2'b00, 2'd3, 4'b0110, 5'd0, 2, 0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cim_row_ctrl.md
CIM_ROW_CTRL -- requirements
Module: cim_row_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  in  1  Single clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  Synchronous active-low reset.
REQ-004 cmd_valid  in  1  Command present.
REQ-005 cmd_ready  out  1  Block can accept a command.
REQ-006 cmd_op  in  2  Opcode: 00 WRITE, 01 READ, 10 SEARCH (CAM), 11 MAC.
REQ-007 cmd_addr  in  2  Row address for WRITE and READ; ignored for SEARCH and MAC.
REQ-008 cmd_data  in  4  Write data for WRITE, key for SEARCH, input vector for MAC; ignored for READ.
REQ-009 MAC_en, read_bar, addr0, addr1, data0..data3  out  1 each  Row-decoder control inputs.
REQ-010 bl_data  out  4  Bitline write data.
REQ-011 precharge  out  1  Bitline/matchline precharge strobe.
REQ-012 sense_en  out  1  Sense-amp enable strobe.
REQ-013 sa_out  in  4  Sense-amp or matchline results, sampled in the SENSE state.
REQ-014 rsp_valid  out  1  Response present.
REQ-015 rsp_ready  in  1  Consumer accepts the response.
REQ-016 rsp_data  out  5  Result.
REQ-017 busy  out  1  High whenever the state is not IDLE.

Function
REQ-018 FSM states SHALL be: IDLE, PRE, ACT, SENSE, DONE.
REQ-019 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted when cmd_valid and cmd_ready are both 1, with cmd_op, cmd_addr and cmd_data registered at that edge.
REQ-020 In IDLE and DONE, the outputs SHALL be: MAC_en=0, data0..3=0, addr=0, read_bar=0, bl_data=0, precharge=0, sense_en=0. This drives all WL low and all WLB high.
REQ-021 WRITE SHALL go IDLE -> ACT -> DONE.
  - In ACT: MAC_en=1, read_bar=1, {addr1,addr0}=cmd_addr, bl_data=cmd_data.
  - rsp_data=0.
REQ-022 READ SHALL go IDLE -> PRE -> ACT -> SENSE -> DONE.
  - In ACT and SENSE: MAC_en=1, read_bar=0, {addr1,addr0}=cmd_addr.
  - rsp_data={0, sa_out sampled in SENSE}.
REQ-023 SEARCH SHALL follow the same sequence as READ.
  - In ACT and SENSE: MAC_en=0, {data3..data0}=cmd_data.
  - rsp_data={0, sa_out sampled in SENSE}.
REQ-024 MAC SHALL run the PRE -> ACT -> SENSE sequence four times, for rows r=0,1,2,3 in order, then go to DONE.
  - ACT/SENSE drive MAC_en=1, read_bar=0, {addr1,addr0}=r.
  - In each SENSE: acc += popcount(sa_out & cmd_data).
  - rsp_data=acc (max 16; 5 bits; no overflow possible).
REQ-025 acc SHALL clear to 0 when a MAC command is accepted.
REQ-026 precharge SHALL be 1 only in PRE, and sense_en SHALL be 1 only in SENSE; each strobe SHALL last exactly one cycle per row pass.
REQ-027 Latency, with acceptance at edge T:
  - WRITE: rsp_valid first high in cycle T+2.
  - READ/SEARCH: T+4.
  - MAC: T+13.
REQ-028 rsp_valid SHALL be 1 only in DONE, and rsp_data SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-029 DONE SHALL exit to IDLE on the edge where rsp_ready=1; cmd_ready SHALL rise the following cycle, with no same-cycle command bypass.
REQ-030 cmd_valid asserted while the block is not in IDLE SHALL be ignored, with no effect on the operation in flight.
REQ-031 The row counter SHALL be 2 bits; the transition out of row 3's SENSE SHALL go to DONE and SHALL NOT wrap to row 0.
REQ-032 All outputs SHALL be registered or decoded from state only; no output SHALL depend combinationally on cmd_* or rsp_ready.

Reset
REQ-033 When rst_n=0 at a clock edge, the block SHALL enter IDLE and clear acc, the row counter and the command registers to 0.
REQ-034 During reset, all outputs SHALL hold the IDLE values: rsp_valid=0, rsp_data=0, busy=0. cmd_ready SHALL be 0 while rst_n=0 and SHALL be 1 in the first cycle after release.
REQ-035 Reset asserted mid-operation SHALL abort the operation; no response SHALL be produced for the aborted command.

Verification
REQ-036 WRITE op=00, addr=2, data=1011 -> in T+1: MAC_en=1, read_bar=1, addr1=1, addr0=0, bl_data=1011; rsp_valid=1 at T+2 with rsp_data=0.
REQ-037 READ addr=1, sa_out=0110 in SENSE -> precharge at T+1, sense_en at T+3, rsp_data=00110 at T+4; with rsp_ready held low 3 cycles, rsp_data stays stable.
REQ-038 SEARCH key=1100, sa_out=0001 -> MAC_en=0 and data3..0=1100 in ACT/SENSE; rsp_data=00001.
REQ-039 MAC data=1111, sa_out=1111 for all rows -> row addresses 0,1,2,3 in order, 4 precharge and 4 sense_en pulses, rsp_data=10000 (16) at T+13.
REQ-040 rst_n=0 during MAC row 2 -> next cycle IDLE outputs, busy=0, no rsp_valid; a subsequent READ completes normally with correct data.
